// File: rtl/player_motion_ctrl.sv
// Player motion controller for one gameplay stage.
// Moves the 20x20 player sprite on a fixed movement tick within the playfield,
// collects the three key pickups and reports the door being reached with all keys.
module player_motion_ctrl #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int SPRITE   = 20,
  parameter int STEP     = 2,
  parameter int TICK_DIV = 1000000,
  parameter int START_X  = 10,
  parameter int START_Y  = 110,
  parameter int KEY0_X   = 80,
  parameter int KEY0_Y   = 40,
  parameter int KEY1_X   = 200,
  parameter int KEY1_Y   = 180,
  parameter int KEY2_X   = 260,
  parameter int KEY2_Y   = 60,
  parameter int DOOR_X   = 290,
  parameter int DOOR_Y   = 110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stage_active,
  input  logic       stage_start,
  input  logic       key_w,
  input  logic       key_a,
  input  logic       key_s,
  input  logic       key_d,
  output logic [8:0] player_x,
  output logic [8:0] player_y,
  output logic [2:0] key_taken,
  output logic [1:0] key_find,
  output logic       pass,
  output logic       move_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  localparam logic [9:0] SPR    = 10'(SPRITE);
  localparam logic [9:0] STEP_W = 10'(STEP);
  localparam logic [9:0] MAX_X  = 10'(SCREEN_W - SPRITE);
  localparam logic [9:0] MAX_Y  = 10'(SCREEN_H - SPRITE);
  localparam logic [8:0] INIT_X = 9'(START_X);
  localparam logic [8:0] INIT_Y = 9'(START_Y);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic [2:0]    taken_q, taken_d;
  logic [1:0]    find_q, find_d;
  logic          pass_q, pass_d;

  logic [9:0]    posX;
  logic [9:0]    posY;
  logic [2:0]    keyHit;
  logic          doorHit;
  logic          tickNow;

  // Strict AABB overlap of two SPRITE-sized squares; touching edges do not count.
  function automatic logic overlap(input logic [9:0] px, input logic [9:0] py,
                                   input logic [9:0] ox, input logic [9:0] oy);
    return (px < ox + SPR) && (ox < px + SPR) && (py < oy + SPR) && (oy < py + SPR);
  endfunction

  // One axis step: the 10-bit intermediate exposes underflow through bit 9 before clamping.
  function automatic logic [8:0] stepAxis(input logic [8:0] pos, input logic inc,
                                          input logic dec, input logic [9:0] maxPos);
    logic [9:0] wide;
    wide = {1'b0, pos};
    if (inc && !dec) begin
      wide = wide + STEP_W;
      if (wide > maxPos) wide = maxPos;
    end else if (dec && !inc) begin
      wide = wide - STEP_W;
      if (wide[9]) wide = '0;
    end
    return wide[8:0];
  endfunction

  assign posX    = {1'b0, x_q};
  assign posY    = {1'b0, y_q};
  assign keyHit[0] = overlap(posX, posY, 10'(KEY0_X), 10'(KEY0_Y));
  assign keyHit[1] = overlap(posX, posY, 10'(KEY1_X), 10'(KEY1_Y));
  assign keyHit[2] = overlap(posX, posY, 10'(KEY2_X), 10'(KEY2_Y));
  assign doorHit   = overlap(posX, posY, 10'(DOOR_X), 10'(DOOR_Y));

  // A tick only counts while the stage is really running and not being restarted.
  assign tickNow = (state_q == PLAY) && stage_active && !stage_start && (cnt_q == TICK_LAST);

  assign player_x  = x_q;
  assign player_y  = y_q;
  assign key_taken = taken_q;
  assign key_find  = find_q;
  assign pass      = pass_q;
  assign move_tick = tickNow;

  // State, counter, position and key registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= INIT_X;
      y_q     <= INIT_Y;
      taken_q <= '0;
      find_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      taken_q <= taken_d;
      find_q  <= find_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic: restart has top priority, then stage drop, then door, then motion/pickups.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    taken_d = taken_q;
    find_d  = find_q;
    pass_d  = 1'b0;

    if (stage_start) begin
      state_d = PLAY;
      cnt_d   = '0;
      x_d     = INIT_X;
      y_d     = INIT_Y;
      taken_d = '0;
      find_d  = '0;
    end else begin
      case (state_q)
        PLAY: begin
          if (!stage_active) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (doorHit && (find_q == 2'd3)) begin
            state_d = DONE;
            cnt_d   = '0;
            pass_d  = 1'b1;
          end else begin
            cnt_d = tickNow ? '0 : cnt_q + CW'(1);
            if (tickNow) begin
              x_d = stepAxis(x_q, key_d, key_a, MAX_X);
              y_d = stepAxis(y_q, key_s, key_w, MAX_Y);
            end
            if (keyHit[0] && !taken_q[0]) begin
              taken_d[0] = 1'b1;
              find_d     = (find_q == 2'd3) ? 2'd3 : find_q + 2'd1;
            end else if (keyHit[1] && !taken_q[1]) begin
              taken_d[1] = 1'b1;
              find_d     = (find_q == 2'd3) ? 2'd3 : find_q + 2'd1;
            end else if (keyHit[2] && !taken_q[2]) begin
              taken_d[2] = 1'b1;
              find_d     = (find_q == 2'd3) ? 2'd3 : find_q + 2'd1;
            end
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed testbench for player_motion_ctrl with a 4-cycle movement tick.
module tb_player_motion_ctrl;

  logic       clk;
  logic       rst;
  logic       stage_active;
  logic       stage_start;
  logic       key_w;
  logic       key_a;
  logic       key_s;
  logic       key_d;
  logic [8:0] player_x;
  logic [8:0] player_y;
  logic [2:0] key_taken;
  logic [1:0] key_find;
  logic       pass;
  logic       move_tick;

  int checks = 0;
  int errors = 0;
  int passCount = 0;
  int tickCount = 0;
  int passBefore;
  int tickBefore;

  player_motion_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .stage_active(stage_active),
    .stage_start(stage_start),
    .key_w(key_w),
    .key_a(key_a),
    .key_s(key_s),
    .key_d(key_d),
    .player_x(player_x),
    .player_y(player_y),
    .key_taken(key_taken),
    .key_find(key_find),
    .pass(pass),
    .move_tick(move_tick)
  );

  // 100 MHz-style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pass and tick pulses away from the active edge
  always @(negedge clk) begin
    if (pass === 1'b1) passCount++;
    if (move_tick === 1'b1) tickCount++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input int n);
    step(4 * n);
  endtask

  task automatic applyStimulus(input logic w, input logic a, input logic s, input logic d);
    key_w = w;
    key_a = a;
    key_s = s;
    key_d = d;
  endtask

  task automatic startStage();
    stage_active = 1'b1;
    stage_start  = 1'b1;
    step(1);
    stage_start  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stage_active = 1'b0;
    stage_start = 1'b0;
    applyStimulus(0, 0, 0, 0);
    step(3);
    checks++; if (player_x !== 9'd10) begin errors++; $display("[TB] FAIL reset_x: got %0d expected 10", player_x); end
    checks++; if (player_y !== 9'd110) begin errors++; $display("[TB] FAIL reset_y: got %0d expected 110", player_y); end
    checks++; if (key_taken !== 3'b000) begin errors++; $display("[TB] FAIL reset_taken: got %b expected 000", key_taken); end
    checks++; if (key_find !== 2'd0) begin errors++; $display("[TB] FAIL reset_find: got %0d expected 0", key_find); end
    checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass: got %b expected 0", pass); end
    checks++; if (move_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick: got %b expected 0", move_tick); end
    rst = 1'b0;
    stage_active = 1'b1;
    applyStimulus(0, 0, 0, 1);
    step(12);
    checks++; if (tickCount !== 0) begin errors++; $display("[TB] FAIL idle_no_tick: got %0d expected 0", tickCount); end
    checks++; if (player_x !== 9'd10) begin errors++; $display("[TB] FAIL idle_no_move: got %0d expected 10", player_x); end
  endtask

  task automatic test_right();
    applyStimulus(0, 0, 0, 1);
    startStage();
    for (int k = 1; k <= 10; k++) begin
      step(3);
      checks++; if (move_tick !== 1'b1) begin errors++; $display("[TB] FAIL right_tick_hi[%0d]: got %b expected 1", k, move_tick); end
      step(1);
      checks++; if (move_tick !== 1'b0) begin errors++; $display("[TB] FAIL right_tick_lo[%0d]: got %b expected 0", k, move_tick); end
      checks++; if (player_x !== 9'(10 + 2 * k)) begin errors++; $display("[TB] FAIL right_x[%0d]: got %0d expected %0d", k, player_x, 10 + 2 * k); end
    end
    checks++; if (player_y !== 9'd110) begin errors++; $display("[TB] FAIL right_y: got %0d expected 110", player_y); end
  endtask

  task automatic test_left_and_down();
    int expX[10] = '{8, 6, 4, 2, 0, 0, 0, 0, 0, 0};
    applyStimulus(0, 1, 0, 0);
    startStage();
    checks++; if (player_x !== 9'd10) begin errors++; $display("[TB] FAIL restart_x: got %0d expected 10", player_x); end
    for (int k = 0; k < 10; k++) begin
      tick(1);
      checks++; if (player_x !== 9'(expX[k])) begin errors++; $display("[TB] FAIL left_x[%0d]: got %0d expected %0d", k, player_x, expX[k]); end
    end
    applyStimulus(0, 0, 1, 0);
    startStage();
    tick(54);
    checks++; if (player_y !== 9'd218) begin errors++; $display("[TB] FAIL down_y54: got %0d expected 218", player_y); end
    tick(1);
    checks++; if (player_y !== 9'd220) begin errors++; $display("[TB] FAIL down_y55: got %0d expected 220", player_y); end
    tick(5);
    checks++; if (player_y !== 9'd220) begin errors++; $display("[TB] FAIL down_sat: got %0d expected 220", player_y); end
    checks++; if (player_x !== 9'd10) begin errors++; $display("[TB] FAIL down_x: got %0d expected 10", player_x); end
  endtask

  task automatic test_both_and_diag();
    applyStimulus(0, 1, 0, 1);
    startStage();
    tick(3);
    checks++; if (player_x !== 9'd10) begin errors++; $display("[TB] FAIL ad_x: got %0d expected 10", player_x); end
    applyStimulus(1, 0, 0, 1);
    step(3);
    checks++; if (move_tick !== 1'b1) begin errors++; $display("[TB] FAIL diag_tick: got %b expected 1", move_tick); end
    checks++; if (player_y !== 9'd110) begin errors++; $display("[TB] FAIL diag_y_before: got %0d expected 110", player_y); end
    step(1);
    checks++; if (player_x !== 9'd12) begin errors++; $display("[TB] FAIL diag_x: got %0d expected 12", player_x); end
    checks++; if (player_y !== 9'd108) begin errors++; $display("[TB] FAIL diag_y: got %0d expected 108", player_y); end
  endtask

  task automatic test_key_pickup();
    applyStimulus(1, 0, 0, 1);
    startStage();
    tick(25);
    applyStimulus(1, 0, 0, 0);
    tick(10);
    checks++; if (player_x !== 9'd60 || player_y !== 9'd40) begin errors++; $display("[TB] FAIL key_pos: got (%0d,%0d) expected (60,40)", player_x, player_y); end
    checks++; if (key_taken !== 3'b000) begin errors++; $display("[TB] FAIL key_edge: got %b expected 000", key_taken); end
    applyStimulus(0, 0, 0, 1);
    tick(1);
    checks++; if (key_taken !== 3'b000) begin errors++; $display("[TB] FAIL key_not_yet: got %b expected 000", key_taken); end
    step(1);
    checks++; if (key_taken !== 3'b001) begin errors++; $display("[TB] FAIL key0_taken: got %b expected 001", key_taken); end
    checks++; if (key_find !== 2'd1) begin errors++; $display("[TB] FAIL key0_find: got %0d expected 1", key_find); end
    applyStimulus(0, 0, 0, 0);
    step(3);
    tick(2);
    checks++; if (key_find !== 2'd1) begin errors++; $display("[TB] FAIL key0_stay: got %0d expected 1", key_find); end
  endtask

  task automatic test_door();
    applyStimulus(0, 0, 1, 1);
    tick(10);
    applyStimulus(0, 0, 0, 1);
    tick(80);
    applyStimulus(0, 0, 0, 0);
    tick(1);
    checks++; if (key_find !== 2'd2) begin errors++; $display("[TB] FAIL key2_find: got %0d expected 2", key_find); end
    checks++; if (key_taken !== 3'b101) begin errors++; $display("[TB] FAIL key2_taken: got %b expected 101", key_taken); end
    applyStimulus(0, 0, 1, 0);
    tick(25);
    passBefore = passCount;
    applyStimulus(0, 0, 0, 1);
    tick(15);
    applyStimulus(0, 0, 0, 0);
    tick(1);
    checks++; if (passCount !== passBefore) begin errors++; $display("[TB] FAIL door_two_keys: got %0d pulses expected 0", passCount - passBefore); end
    checks++; if (player_x !== 9'd272 || player_y !== 9'd110) begin errors++; $display("[TB] FAIL door_pos: got (%0d,%0d) expected (272,110)", player_x, player_y); end
    applyStimulus(0, 0, 0, 1);
    tick(14);
    checks++; if (player_x !== 9'd300) begin errors++; $display("[TB] FAIL right_sat: got %0d expected 300", player_x); end
    applyStimulus(0, 0, 1, 0);
    tick(35);
    applyStimulus(0, 1, 0, 0);
    tick(40);
    checks++; if (key_taken !== 3'b101) begin errors++; $display("[TB] FAIL key1_edge: got %b expected 101", key_taken); end
    tick(1);
    applyStimulus(0, 0, 0, 0);
    tick(1);
    checks++; if (key_taken !== 3'b111) begin errors++; $display("[TB] FAIL key1_taken: got %b expected 111", key_taken); end
    checks++; if (key_find !== 2'd3) begin errors++; $display("[TB] FAIL key1_find: got %0d expected 3", key_find); end
    applyStimulus(1, 0, 0, 1);
    tick(25);
    applyStimulus(0, 0, 0, 1);
    tick(2);
    checks++; if (passCount !== passBefore) begin errors++; $display("[TB] FAIL door_edge: got %0d pulses expected 0", passCount - passBefore); end
    applyStimulus(1, 0, 0, 0);
    tick(1);
    checks++; if (player_y !== 9'd128 || pass !== 1'b0) begin errors++; $display("[TB] FAIL door_enter: got y=%0d pass=%b expected y=128 pass=0", player_y, pass); end
    step(1);
    checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL pass_hi: got %b expected 1", pass); end
    step(1);
    checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL pass_lo: got %b expected 0", pass); end
    checks++; if (passCount - passBefore !== 1) begin errors++; $display("[TB] FAIL pass_width: got %0d expected 1", passCount - passBefore); end
    tickBefore = tickCount;
    applyStimulus(0, 0, 1, 1);
    step(20);
    checks++; if (player_x !== 9'd272 || player_y !== 9'd128) begin errors++; $display("[TB] FAIL done_freeze: got (%0d,%0d) expected (272,128)", player_x, player_y); end
    checks++; if (tickCount !== tickBefore) begin errors++; $display("[TB] FAIL done_no_tick: got %0d expected 0", tickCount - tickBefore); end
    applyStimulus(0, 0, 0, 0);
    startStage();
    checks++; if (player_x !== 9'd10 || player_y !== 9'd110) begin errors++; $display("[TB] FAIL restart_pos: got (%0d,%0d) expected (10,110)", player_x, player_y); end
    checks++; if (key_find !== 2'd0 || key_taken !== 3'b000) begin errors++; $display("[TB] FAIL restart_keys: got find=%0d taken=%b expected 0/000", key_find, key_taken); end
  endtask

  task automatic test_inactive();
    applyStimulus(0, 0, 0, 1);
    startStage();
    tick(2);
    step(2);
    stage_active = 1'b0;
    step(1);
    tickBefore = tickCount;
    step(20);
    checks++; if (player_x !== 9'd14) begin errors++; $display("[TB] FAIL inactive_x: got %0d expected 14", player_x); end
    checks++; if (tickCount !== tickBefore) begin errors++; $display("[TB] FAIL inactive_tick: got %0d expected 0", tickCount - tickBefore); end
    stage_active = 1'b1;
    step(12);
    checks++; if (player_x !== 9'd14) begin errors++; $display("[TB] FAIL reactivate_x: got %0d expected 14", player_x); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 0, 0, 1);
    startStage();
    tick(26);
    applyStimulus(0, 0, 0, 1);
    tick(90);
    applyStimulus(0, 0, 0, 0);
    tick(1);
    checks++; if (key_find !== 2'd2) begin errors++; $display("[TB] FAIL mid_find: got %0d expected 2", key_find); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (player_x !== 9'd10 || player_y !== 9'd110) begin errors++; $display("[TB] FAIL rst_pos: got (%0d,%0d) expected (10,110)", player_x, player_y); end
    checks++; if (key_find !== 2'd0 || key_taken !== 3'b000) begin errors++; $display("[TB] FAIL rst_keys: got find=%0d taken=%b expected 0/000", key_find, key_taken); end
    checks++; if (pass !== 1'b0 || move_tick !== 1'b0) begin errors++; $display("[TB] FAIL rst_pulses: got pass=%b tick=%b expected 0/0", pass, move_tick); end
    step(2);
    rst = 1'b0;
  endtask

  // Run every scenario in order and print the summary
  initial begin
    test_reset();
    test_right();
    test_left_and_down();
    test_both_and_diag();
    test_key_pickup();
    test_door();
    test_inactive();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
